// File: rtl/tensor_core_mma_seq_if.sv
// tensor_core_mma_seq_if: operand, dot-product job/result and D-matrix handshakes of the MMA sequencer.
// ACC_CHAIN_EN adds the acc_chain operand-side input.
interface tensor_core_mma_seq_if #(
    parameter int DWIDTH = 16,
    parameter int DIM    = 4
);
    localparam int IDX_W = $clog2(DIM * DIM);
    logic                        in_valid;
    logic                        in_ready;
    logic [DIM*DIM*DWIDTH-1:0]   a_in;
    logic [DIM*DIM*DWIDTH-1:0]   b_in;
    logic [DIM*DIM*DWIDTH-1:0]   c_in;
`ifdef ACC_CHAIN_EN
    logic                        acc_chain;
`endif
    logic                        dp_valid;
    logic                        dp_ready;
    logic [DIM*DWIDTH-1:0]       dp_a;
    logic [DIM*DWIDTH-1:0]       dp_b;
    logic [DWIDTH-1:0]           dp_c;
    logic [IDX_W-1:0]            dp_tag;
    logic                        dp_res_valid;
    logic [DWIDTH-1:0]           dp_res;
    logic                        out_valid;
    logic                        out_ready;
    logic [DIM*DIM*DWIDTH-1:0]   c_out;
    logic                        busy;
    logic                        err;

    modport slave (
`ifdef ACC_CHAIN_EN
        input  acc_chain,
`endif
        input  in_valid, a_in, b_in, c_in, dp_ready, dp_res_valid, dp_res, out_ready,
        output in_ready, dp_valid, dp_a, dp_b, dp_c, dp_tag, out_valid, c_out, busy, err
    );

    modport master (
`ifdef ACC_CHAIN_EN
        output acc_chain,
`endif
        output in_valid, a_in, b_in, c_in, dp_ready, dp_res_valid, dp_res, out_ready,
        input  in_ready, dp_valid, dp_a, dp_b, dp_c, dp_tag, out_valid, c_out, busy, err
    );
endinterface

// File: rtl/tensor_core_mma_seq.sv
// tensor_core_mma_seq: D = A*B + C sequencer issuing one dot-product job per element to an external FP unit.
// Define ACC_CHAIN_EN to let acc_chain take C from the previous D held in the result buffer.
module tensor_core_mma_seq #(
    parameter int DWIDTH = 16,
    parameter int DIM    = 4
) (
    input logic                  clk,
    input logic                  rst,
    tensor_core_mma_seq_if.slave bus
);
    localparam int NEL   = DIM * DIM;
    localparam int IDX_W = $clog2(NEL);
    localparam int CNT_W = $clog2(NEL + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NEL - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, OUT} state_t;

    state_t                  r_state;
    logic [NEL*DWIDTH-1:0]   r_a;
    logic [NEL*DWIDTH-1:0]   r_b;
    logic [NEL*DWIDTH-1:0]   r_c;
    logic [NEL*DWIDTH-1:0]   r_res;
    logic [CNT_W-1:0]        r_iss_idx;
    logic [CNT_W-1:0]        r_res_idx;
    logic                    r_in_ready;
    logic                    r_dp_valid;
    logic                    r_out_valid;
    logic                    r_busy;
    logic                    r_err;
    logic [IDX_W-1:0]        w_idx;
    logic                    w_iss_fire;
    logic                    w_res_fire;
    logic [NEL*DWIDTH-1:0]   w_c_src;

    assign w_idx      = r_iss_idx[IDX_W-1:0];
    assign w_iss_fire = r_dp_valid && bus.dp_ready;
    // A result is only legal while a job is outstanding; equal counters means none is.
    assign w_res_fire = bus.dp_res_valid && (r_res_idx != r_iss_idx);
`ifdef ACC_CHAIN_EN
    assign w_c_src = bus.acc_chain ? r_res : bus.c_in;
`else
    assign w_c_src = bus.c_in;
`endif

    always_comb begin
        bus.dp_a = '0;
        bus.dp_b = '0;
        for (int k = 0; k < DIM; k++) begin
            bus.dp_a[k*DWIDTH +: DWIDTH] = r_a[((int'(w_idx) / DIM) * DIM + k)*DWIDTH +: DWIDTH];
            bus.dp_b[k*DWIDTH +: DWIDTH] = r_b[(k * DIM + int'(w_idx) % DIM)*DWIDTH +: DWIDTH];
        end
    end

    assign bus.dp_c      = r_c[int'(w_idx)*DWIDTH +: DWIDTH];
    assign bus.dp_tag    = w_idx;
    assign bus.dp_valid  = r_dp_valid;
    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.c_out     = r_res;
    assign bus.busy      = r_busy;
    assign bus.err       = r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_c         <= '0;
            r_res       <= '0;
            r_iss_idx   <= '0;
            r_res_idx   <= '0;
            r_in_ready  <= 1'b1;
            r_dp_valid  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            if (w_res_fire) begin
                r_res[int'(r_res_idx[IDX_W-1:0])*DWIDTH +: DWIDTH] <= bus.dp_res;
                r_res_idx <= r_res_idx + 1'b1;
            end
            if (bus.dp_res_valid && !w_res_fire)
                r_err <= 1'b1;
            if (w_iss_fire)
                r_iss_idx <= r_iss_idx + 1'b1;
            case (r_state)
                IDLE: if (bus.in_valid) begin
                    r_a        <= bus.a_in;
                    r_b        <= bus.b_in;
                    r_c        <= w_c_src;
                    r_iss_idx  <= '0;
                    r_res_idx  <= '0;
                    r_in_ready <= 1'b0;
                    r_dp_valid <= 1'b1;
                    r_busy     <= 1'b1;
                    r_state    <= ISSUE;
                end
                ISSUE: if (w_iss_fire && r_iss_idx == LAST) begin
                    r_dp_valid <= 1'b0;
                    r_state    <= DRAIN;
                end
                DRAIN: if (w_res_fire && r_res_idx == LAST) begin
                    r_out_valid <= 1'b1;
                    r_state     <= OUT;
                end
                OUT: if (bus.out_ready) begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_tensor_core_mma_seq.sv
// tb_tensor_core_mma_seq: directed MMA sequences against a small-integer fp16 dot-product model of latency 3.
module tb_tensor_core_mma_seq;
    localparam int DW  = 16;
    localparam int DIM = 4;
    localparam int L   = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic inj = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;
    int   lat;
    logic [3:0]  q_tag[$];
    logic [15:0] q_c[$];
    logic [L-1:0] st_v;
    logic [15:0]  st_r[L];

    always #5 clk = ~clk;

    tensor_core_mma_seq_if #(.DWIDTH(DW), .DIM(DIM)) bus();
    tensor_core_mma_seq #(.DWIDTH(DW), .DIM(DIM)) dut(.clk(clk), .rst(rst), .bus(bus));

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic int h2i(input logic [15:0] h);
        case (h)
            16'h0000: return 0;
            16'h3C00: return 1;
            16'h4000: return 2;
            16'h4200: return 3;
            16'h4400: return 4;
            16'h4500: return 5;
            16'h4600: return 6;
            16'h4700: return 7;
            16'h4800: return 8;
            16'h4880: return 9;
            default:  return -100;
        endcase
    endfunction

    function automatic logic [15:0] i2h(input int v);
        case (v)
            0: return 16'h0000;
            1: return 16'h3C00;
            2: return 16'h4000;
            3: return 16'h4200;
            4: return 16'h4400;
            5: return 16'h4500;
            6: return 16'h4600;
            7: return 16'h4700;
            8: return 16'h4800;
            9: return 16'h4880;
            default: return 16'hFFFF;
        endcase
    endfunction

    function automatic logic [15:0] dot(input logic [63:0] a, input logic [63:0] b, input logic [15:0] c);
        int s = h2i(c);
        for (int k = 0; k < DIM; k++) s += h2i(a[k*16 +: 16]) * h2i(b[k*16 +: 16]);
        return i2h(s);
    endfunction

    function automatic logic [255:0] mat(input logic [15:0] d, input logic [15:0] o);
        logic [255:0] m = '0;
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++) m[(r*DIM+c)*16 +: 16] = (r == c) ? d : o;
        return m;
    endfunction

    function automatic logic [255:0] tags_packed();
        logic [255:0] v = '0;
        foreach (q_tag[i]) if (i < 64) v[i*4 +: 4] = q_tag[i];
        return v;
    endfunction

    function automatic logic [255:0] dpc_packed();
        logic [255:0] v = '0;
        foreach (q_c[i]) if (i < 16) v[i*16 +: 16] = q_c[i];
        return v;
    endfunction

    always @(posedge clk) begin
        if (rst) st_v <= '0;
        else begin
            st_v <= {st_v[L-2:0], bus.dp_valid && bus.dp_ready};
            st_r[0] <= dot(bus.dp_a, bus.dp_b, bus.dp_c);
            for (int i = 1; i < L; i++) st_r[i] <= st_r[i-1];
        end
    end

    assign bus.dp_res_valid = st_v[L-1] | inj;
    assign bus.dp_res       = st_r[L-1];

    always @(posedge clk) begin
        if (!rst && bus.dp_valid && bus.dp_ready) begin
            q_tag.push_back(bus.dp_tag);
            q_c.push_back(bus.dp_c);
        end
    end

    task automatic run_op(input logic [255:0] a, input logic [255:0] b, input logic [255:0] c,
                          input logic ch, input logic stall, output int n);
        logic [3:0]   pat = 4'b1001;
        logic         prev_stall = 1'b0;
        logic [255:0] snap = '0;
        q_tag.delete();
        q_c.delete();
        @(negedge clk);
        bus.a_in = a;
        bus.b_in = b;
        bus.c_in = c;
`ifdef ACC_CHAIN_EN
        bus.acc_chain = ch;
`else
        if (ch) $display("note: acc_chain requested but not built in");
`endif
        bus.in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            bus.in_valid = 1'b0;
            if (stall) begin
                if (prev_stall) chk("stall_hold", {bus.dp_a, bus.dp_b, bus.dp_c, bus.dp_tag}, snap);
                bus.dp_ready = pat[3 - (n % 4)];
                prev_stall = bus.dp_valid && !bus.dp_ready;
                snap = {bus.dp_a, bus.dp_b, bus.dp_c, bus.dp_tag};
            end
        end while (!bus.out_valid && n < 300);
        bus.dp_ready = 1'b1;
        chk("out_valid_reached", bus.out_valid, 1);
    endtask

    task automatic finish_out();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("out_released", {bus.out_valid, bus.in_ready}, 2'b01);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.a_in      = '0;
        bus.b_in      = '0;
        bus.c_in      = '0;
        bus.dp_ready  = 1'b1;
        bus.out_ready = 1'b0;
`ifdef ACC_CHAIN_EN
        bus.acc_chain = 1'b0;
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_dp_valid", bus.dp_valid, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_c_out", bus.c_out, 0);

        run_op(mat(16'h3C00, 16'h0000), mat(16'h3C00, 16'h0000), '0, 1'b0, 1'b0, lat);
        chk("ident_latency", lat, 20);
        chk("ident_d", bus.c_out, mat(16'h3C00, 16'h0000));
        chk("ident_jobs", q_tag.size(), 16);
        chk("ident_tags", tags_packed(), 256'hFEDCBA9876543210);
        finish_out();
        chk("ident_d_held", bus.c_out, mat(16'h3C00, 16'h0000));

        run_op({16{16'h3C00}}, {16{16'h4000}}, {16{16'h3C00}}, 1'b0, 1'b0, lat);
        chk("nine_d", bus.c_out, {16{16'h4880}});
        chk("nine_tags", tags_packed(), 256'hFEDCBA9876543210);
        finish_out();

        run_op(mat(16'h4000, 16'h3C00), mat(16'h3C00, 16'h0000), '0, 1'b0, 1'b1, lat);
        chk("stall_jobs", q_tag.size(), 16);
        chk("stall_tags", tags_packed(), 256'hFEDCBA9876543210);
        chk("stall_d", bus.c_out, mat(16'h4000, 16'h3C00));

        bus.a_in = mat(16'h3C00, 16'h0000);
        bus.b_in = mat(16'h3C00, 16'h0000);
        bus.c_in = '0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_flags", {bus.out_valid, bus.in_ready, bus.busy}, 3'b101);
            chk("hold_d", bus.c_out, mat(16'h4000, 16'h3C00));
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("resume_idle", {bus.in_ready, bus.out_valid, bus.busy}, 3'b100);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("resume_accept", {bus.in_ready, bus.busy}, 2'b01);
        lat = 0;
        while (!bus.out_valid && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        chk("resume_out_valid", bus.out_valid, 1);
        chk("resume_d", bus.c_out, mat(16'h3C00, 16'h0000));
        finish_out();

        inj = 1'b1;
        @(negedge clk);
        inj = 1'b0;
        chk("spurious_err", bus.err, 1);
        repeat (3) @(negedge clk);
        chk("err_sticky", bus.err, 1);

        q_tag.delete();
        bus.a_in = {16{16'h3C00}};
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 0;
        while (q_tag.size() < 7 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk("mid_issue_count", q_tag.size(), 7);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_flags", {bus.dp_valid, bus.busy, bus.in_ready, bus.err, bus.out_valid}, 5'b00100);
        chk("midrst_c_out", bus.c_out, 0);

`ifdef ACC_CHAIN_EN
        run_op(mat(16'h3C00, 16'h0000), mat(16'h3C00, 16'h0000), {16{16'h3C00}}, 1'b0, 1'b0, lat);
        chk("chain_op1_d", bus.c_out, mat(16'h4000, 16'h3C00));
        finish_out();
        run_op(mat(16'h3C00, 16'h0000), mat(16'h3C00, 16'h0000), '0, 1'b1, 1'b0, lat);
        chk("chain_dp_c", dpc_packed(), mat(16'h4000, 16'h3C00));
        chk("chain_op2_d", bus.c_out, mat(16'h4200, 16'h3C00));
        finish_out();
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
